// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, FSM state encoding and decode helpers for dmem_responder.
package dmem_pkg;

  localparam int DMEM_DEPTH_WORDS = 128;

  // RV32 load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32 store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // True when funct3 is a supported width code for the given direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Access size in bytes minus one (0, 1 or 3).
  function automatic logic [1:0] size_m1(input logic [2:0] f3);
    logic [1:0] s;
    case (f3[1:0])
      2'b00:   s = 2'd0;
      2'b01:   s = 2'd1;
      2'b10:   s = 2'd3;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_byte_bank.sv
// byte_bank: one 8-bit byte lane of the data memory, synchronous write and
// registered read. Contents are deliberately not reset.
module byte_bank #(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [DEPTH_WORDS];

  // Write the addressed byte and/or register its previous contents.
  always_ff @(posedge clk) begin
    if (we) mem_r[addr] <= wdata;
    if (re) rdata <= mem_r[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32 data-memory responder built from four
// byte banks. Accept -> ACCESS (bank read/write) -> RESP (held until rsp_ready).
// Optional feature: define DMEM_MISALIGN_EN to service misaligned halfword/word
// accesses, including those crossing into the next word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

  state_t      state_r, state_nxt_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r;

  logic [1:0]    off_s, n_m1_s;
  logic [32:0]   last_s;
  logic          range_err_s, align_err_s, err_s;
  logic [AW-1:0] word_s;
`ifdef DMEM_MISALIGN_EN
  logic [AW-1:0] word_p1_s;
`endif
  logic          bank_we_s    [4];
  logic [AW-1:0] bank_addr_s  [4];
  logic [7:0]    bank_wdata_s [4];
  logic [7:0]    bank_rdata_s [4];
  logic [7:0]    lbyte_s      [4];
  logic [31:0]   load_s;

  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = (state_r == ST_RESP);
  assign rsp_err   = (state_r == ST_RESP) & err_s;
  assign rsp_rdata = ((state_r == ST_RESP) && !we_r && !err_s) ? load_s : 32'h0000_0000;

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state: accept in IDLE, one ACCESS cycle, hold RESP until taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = req_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; held through the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
    end else if ((state_r == ST_IDLE) && req_valid) begin
      we_r     <= req_we;
      funct3_r <= req_funct3;
      addr_r   <= req_addr;
      wdata_r  <= req_wdata;
    end
  end

  // Error decode: bad width code, any byte past the end, or forbidden misalignment.
  always_comb begin
    off_s       = addr_r[1:0];
    n_m1_s      = size_m1(funct3_r);
    last_s      = {1'b0, addr_r} + {31'b0, n_m1_s};
    range_err_s = (last_s >= BYTE_LIMIT);
`ifdef DMEM_MISALIGN_EN
    align_err_s = 1'b0;
`else
    case (funct3_r[1:0])
      2'b01:   align_err_s = addr_r[0];
      2'b10:   align_err_s = |addr_r[1:0];
      default: align_err_s = 1'b0;
    endcase
`endif
    err_s = !f3_legal(we_r, funct3_r) | range_err_s | align_err_s;
  end

  assign word_s = addr_r[AW+1:2];
`ifdef DMEM_MISALIGN_EN
  assign word_p1_s = word_s + AW'(1);
`endif

  // Per-lane address, write data and write enable; lanes below the start
  // offset belong to the following word when an access wraps.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      logic [1:0] rel;
      rel = 2'(b) - off_s;
`ifdef DMEM_MISALIGN_EN
      bank_addr_s[b] = (2'(b) < off_s) ? word_p1_s : word_s;
`else
      bank_addr_s[b] = word_s;
`endif
      bank_wdata_s[b] = wdata_r[{rel, 3'b000} +: 8];
      bank_we_s[b]    = (state_r == ST_ACCESS) & we_r & ~err_s & (rel <= n_m1_s);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    byte_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (bank_we_s[g]),
      .re    (state_r == ST_ACCESS),
      .addr  (bank_addr_s[g]),
      .wdata (bank_wdata_s[g]),
      .rdata (bank_rdata_s[g])
    );
  end

  // Rotate bank outputs into access order and apply sign/zero extension.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      logic [1:0] lane;
      lane       = off_s + 2'(k);
      lbyte_s[k] = bank_rdata_s[lane];
    end
    case (funct3_r)
      F3_LB:   load_s = {{24{lbyte_s[0][7]}}, lbyte_s[0]};
      F3_LH:   load_s = {{16{lbyte_s[1][7]}}, lbyte_s[1], lbyte_s[0]};
      F3_LW:   load_s = {lbyte_s[3], lbyte_s[2], lbyte_s[1], lbyte_s[0]};
      F3_LBU:  load_s = {24'h000000, lbyte_s[0]};
      F3_LHU:  load_s = {16'h0000, lbyte_s[1], lbyte_s[0]};
      default: load_s = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against a
// byte-array reference model. Honours DMEM_MISALIGN_EN when defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int BYTES = 4 * 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem_m [BYTES];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, legality from width/direction/range/alignment.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int n;
    logic [63:0] last;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    last = {32'h0, addr} + 64'(n - 1);
    if (last >= 64'(BYTES)) err = 1'b1;
`ifndef DMEM_MISALIGN_EN
    if ((addr % n) != 0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[addr + i];
        if (!f3[2]) for (int i = n; i < 4; i++) v[8*i +: 8] = {8{v[8*n-1]}};
        rdata = v;
      end
    end
  endfunction

  // One full transaction with latency, stability and handshake checks.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int stall,
                      output logic [31:0] got, output logic got_err);
    logic e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    model(we, f3, addr, wdata, e_err, e_rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("rsp_valid_early", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("rsp_valid_lat", 32'(rsp_valid), 32'd1);
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
    got = rsp_rdata; got_err = rsp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SB;
      req_addr = 32'($urandom_range(0, BYTES - 1)); req_wdata = $urandom;
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rdata", rsp_rdata, e_rd);
      check_eq("stall_err", 32'(rsp_err), 32'(e_err));
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rsp_done", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_back", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] got, val;
  logic        gerr, e_err;
  logic [31:0] e_rd;
  logic [2:0]  rf3;
  logic [31:0] raddr;

  initial begin
    #2;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;  // ignored outside RESP
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_rsp_ready_noeffect", 32'(rsp_valid), 32'd0);

    // Make the whole memory known to the model.
    for (int w = 0; w < 128; w++) xact(1'b1, F3_SW, 32'(w * 4), $urandom, 0, got, gerr);

    // Basic store/load and byte lanes
    xact(1'b1, F3_SW, 32'h8, 32'hDEADBEEF, 0, got, gerr);
    xact(1'b0, F3_LW, 32'h8, 32'h0, 0, got, gerr);
    check_eq("lw8", got, 32'hDEADBEEF);
    check_eq("lw8_err", 32'(gerr), 32'd0);
    xact(1'b1, F3_SB, 32'hA, 32'h7F, 0, got, gerr);
    xact(1'b0, F3_LB, 32'hB, 32'h0, 0, got, gerr);
    check_eq("lb_b", got, 32'hFFFFFFDE);
    xact(1'b0, F3_LBU, 32'hA, 32'h0, 0, got, gerr);
    check_eq("lbu_a", got, 32'h0000007F);
    xact(1'b0, F3_LW, 32'h8, 32'h0, 0, got, gerr);
    check_eq("lw8_merged", got, 32'hDE7FBEEF);

    // Misaligned word store
    xact(1'b1, F3_SW, 32'h6, 32'h11223344, 0, got, gerr);
`ifdef DMEM_MISALIGN_EN
    check_eq("sw6_err", 32'(gerr), 32'd0);
    xact(1'b0, F3_LW, 32'h6, 32'h0, 0, got, gerr);
    check_eq("lw6", got, 32'h11223344);
    xact(1'b0, F3_LHU, 32'h7, 32'h0, 0, got, gerr);
    check_eq("lhu7", got, 32'h00002233);
`else
    check_eq("sw6_err", 32'(gerr), 32'd1);
    xact(1'b0, F3_LW, 32'h8, 32'h0, 0, got, gerr);
    check_eq("lw8_unchanged", got, 32'hDE7FBEEF);
`endif

    // Back-pressure in RESP
    xact(1'b0, F3_LW, 32'h10, 32'h0, 5, got, gerr);

    // Range edge and illegal width
    xact(1'b0, F3_LW, 32'h1FC, 32'h0, 0, got, gerr);
    check_eq("lw1fc_err", 32'(gerr), 32'd0);
    xact(1'b0, F3_LW, 32'h1FE, 32'h0, 0, got, gerr);
    check_eq("lw1fe_err", 32'(gerr), 32'd1);
    check_eq("lw1fe_rdata", got, 32'h0);
    xact(1'b0, 3'b011, 32'h0, 32'h0, 0, got, gerr);
    check_eq("f3_011_err", 32'(gerr), 32'd1);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      rf3 = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                           : 32'($urandom_range(0, BYTES + 19));
      xact(1'($urandom_range(0, 1)), rf3, raddr, $urandom, $urandom_range(0, 2), got, gerr);
    end

    // Reset during RESP of a store: written, response aborted.
    val = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h40; req_wdata = val;
    model(1'b1, F3_SW, 32'h40, val, e_err, e_rd);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0; #1;
    check_eq("rst_resp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_resp_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_rdata", rsp_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    xact(1'b0, F3_LW, 32'h40, 32'h0, 0, got, gerr);
    check_eq("lw_after_rst", got, val);

    // Reset during ACCESS of a store: not written.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h44; req_wdata = ~val;
    @(posedge clk); #1 req_valid = 1'b0;
    rst_n = 1'b0; #1;
    check_eq("rst_access_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_access_no_rsp", 32'(rsp_valid), 32'd0);
    xact(1'b0, F3_LW, 32'h44, 32'h0, 0, got, gerr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
